// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with a direct mode (decode a loaded
// index) and a scan mode (step through every output, holding each for DWELL cycles).
module decoder_scan #(
  parameter int IN_W       = 3,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   mode,
  input  logic                   load,
  input  logic [IN_W-1:0]        in,
  output logic [(2**IN_W)-1:0]   out,
  output logic [IN_W-1:0]        idx,
  output logic                   valid,
  output logic                   wrap
);

  localparam int OUT_W = 2 ** IN_W;
  localparam int CNT_W = (DWELL <= 2) ? 1 : $clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [IN_W-1:0]  IDX_LAST = {IN_W{1'b1}};
  localparam logic [OUT_W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IN_W-1:0]  idx_n;
  logic [OUT_W-1:0] out_n;
  logic             valid_n, wrap_n;

  // NOTE: every variable gets a default at the top of always_comb so no
  // branch can leave it unassigned and infer a latch.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    wrap_n  = 1'b0;

    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE, HOLD: begin
          // mode outranks load, so a simultaneous load is dropped on scan entry.
          if (mode) begin
            state_n = SCAN;
            cnt_n   = '0;
          end else if (load) begin
            state_n = HOLD;
            idx_n   = in;
          end
        end
        SCAN: begin
          if (!mode) begin
            state_n = HOLD;
            cnt_n   = '0;
          end else if (cnt == CNT_LAST) begin
            idx_n  = idx + IN_W'(1);
            cnt_n  = '0;
            wrap_n = (idx == IDX_LAST);
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end

    // Outputs are computed from next-state values so they can be registered
    // and still appear in the same cycle as the state they describe.
    valid_n = (state_n != IDLE);
    out_n   = valid_n ? ((OUT_W'(1) << idx_n) ^ INACTIVE) : INACTIVE;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      out   <= INACTIVE;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      out   <= out_n;
      valid <= valid_n;
      wrap  <= wrap_n;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Directed self-checking bench for decoder_scan: an active-high 3-bit
// instance with DWELL=2 and an active-low 2-bit instance with DWELL=1.
module tb_decoder_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: IN_W=3, DWELL=2, active-high.
  logic       rst, en, mode, load;
  logic [2:0] in;
  logic [7:0] out;
  logic [2:0] idx;
  logic       valid, wrap;

  // Second instance: IN_W=2, DWELL=1, active-low.
  logic       a_rst, a_en, a_mode, a_load;
  logic [1:0] a_in;
  logic [3:0] a_out;
  logic [1:0] a_idx;
  logic       a_valid, a_wrap;

  int checks = 0;
  int errors = 0;

  decoder_scan #(.IN_W(3), .DWELL(2), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .in(in),
    .out(out), .idx(idx), .valid(valid), .wrap(wrap)
  );

  decoder_scan #(.IN_W(2), .DWELL(1), .ACTIVE_LOW(1)) u_al (
    .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode), .load(a_load), .in(a_in),
    .out(a_out), .idx(a_idx), .valid(a_valid), .wrap(a_wrap)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic [7:0] e_out, input logic [2:0] e_idx,
                            input logic e_valid, input logic e_wrap);
    check({tag, ".out"},   32'(out),   32'(e_out));
    check({tag, ".idx"},   32'(idx),   32'(e_idx));
    check({tag, ".valid"}, 32'(valid), 32'(e_valid));
    check({tag, ".wrap"},  32'(wrap),  32'(e_wrap));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b0; load = 1'b0; in = 3'd0;
    a_rst = 1'b1; a_en = 1'b1; a_mode = 1'b0; a_load = 1'b0; a_in = 2'd0;
    step(); step();

    // Reset state, then idle with no load.
    check_main("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); step();
    check_main("idle_after_reset", 8'h00, 3'd0, 1'b0, 1'b0);

    // Direct sweep: one load per cycle, visible right after the edge.
    for (int i = 0; i < 8; i++) begin
      load = 1'b1; in = 3'(i);
      step();
      check_main($sformatf("direct_%0d", i), 8'(1) << i, 3'(i), 1'b1, 1'b0);
    end
    load = 1'b1; in = 3'd7;
    step();
    check_main("reload_same", 8'h80, 3'd7, 1'b1, 1'b0);

    // Scan from 6 with a simultaneous load that must be ignored.
    in = 3'd6;
    step();
    load = 1'b1; in = 3'd2; mode = 1'b1;
    step();
    load = 1'b0;
    check_main("scan6_a", 8'h40, 3'd6, 1'b1, 1'b0);
    step(); check_main("scan6_b", 8'h40, 3'd6, 1'b1, 1'b0);
    step(); check_main("scan7_a", 8'h80, 3'd7, 1'b1, 1'b0);
    step(); check_main("scan7_b", 8'h80, 3'd7, 1'b1, 1'b0);
    step(); check_main("scan0_wrap", 8'h01, 3'd0, 1'b1, 1'b1);
    step(); check_main("scan0_b", 8'h01, 3'd0, 1'b1, 1'b0);
    step(); step(); step(); step();
    step(); check_main("scan3", 8'h08, 3'd3, 1'b1, 1'b0);

    // Drop en during idx=3, then resume scanning with a full dwell.
    en = 1'b0;
    step(); check_main("en_off", 8'h00, 3'd3, 1'b0, 1'b0);
    step(); check_main("en_off_b", 8'h00, 3'd3, 1'b0, 1'b0);
    en = 1'b1;
    step(); check_main("resume3_a", 8'h08, 3'd3, 1'b1, 1'b0);
    step(); check_main("resume3_b", 8'h08, 3'd3, 1'b1, 1'b0);
    step(); check_main("resume4", 8'h10, 3'd4, 1'b1, 1'b0);
    step();
    step(); check_main("scan5", 8'h20, 3'd5, 1'b1, 1'b0);
    mode = 1'b0;
    step(); check_main("hold5_a", 8'h20, 3'd5, 1'b1, 1'b0);
    step(); step(); step();
    check_main("hold5_b", 8'h20, 3'd5, 1'b1, 1'b0);

    // Asynchronous reset between edges during SCAN.
    mode = 1'b1;
    step(); check_main("scan_pre_rst", 8'h20, 3'd5, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check_main("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    mode = 1'b0;
    step();
    rst = 1'b0;
    step(); check_main("post_rst_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // Leaving SCAN on what would be the wrap edge suppresses wrap.
    load = 1'b1; in = 3'd7;
    step();
    load = 1'b0; mode = 1'b1;
    step(); step();
    mode = 1'b0;
    step(); check_main("wrap_suppressed", 8'h80, 3'd7, 1'b1, 1'b0);

    // Active-low instance.
    check("al_reset.out", 32'(a_out), 32'h0000000F);
    a_rst = 1'b0;
    a_load = 1'b1; a_in = 2'd2;
    step();
    check("al_load2.out", 32'(a_out), 32'h0000000B);
    a_in = 2'd0;
    step();
    a_load = 1'b0; a_mode = 1'b1;
    step(); check("al_scan0.out", 32'(a_out), 32'h0000000E);
    step(); check("al_scan1.out", 32'(a_out), 32'h0000000D);
    step(); check("al_scan2.out", 32'(a_out), 32'h0000000B);
    step(); check("al_scan3.out", 32'(a_out), 32'h00000007);
            check("al_scan3.wrap", 32'(a_wrap), 32'h0);
    step(); check("al_wrap.out", 32'(a_out), 32'h0000000E);
            check("al_wrap.wrap", 32'(a_wrap), 32'h1);
            check("al_wrap.idx", 32'(a_idx), 32'h0);
            check("al_wrap.valid", 32'(a_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
